// File: rtl/ig_pkg.sv
// Shared definitions for the image-gradient sequencer: FSM states,
// frame geometry, gradient widths and the pixel-difference helper.
package ig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } ig_state_e;

    localparam int IMG_W   = 256;     // width and height in pixels
    localparam int NUM_PIX = 65536;   // pixels per frame
    localparam int GRAD_W  = 20;      // packed {Gx, Gy}
    localparam int G_W     = 10;      // width of each gradient component

    // Difference of two unsigned pixels, both zero-extended before the subtract
    function automatic logic [G_W-1:0] pix_diff(input logic [7:0] a, input logic [7:0] b);
        pix_diff = {2'b00, a} - {2'b00, b};
    endfunction

endpackage

// File: rtl/ig_line_buf.sv
// One-row pixel delay line plus a 1-entry skid register.
// Tap 0 is the pixel presented this cycle (skid first, then the memory
// return); 256 stored stages hold taps 1..256, so tap 256 is the pixel one
// row above tap 0 and tap 255 is its right-hand neighbour.
// The delay line is not reset: FILL overwrites every stage before use.
module ig_line_buf
    import ig_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_px_v,      // memory return valid this cycle
    input  logic [7:0] i_px,        // memory return data
    input  logic       i_shift_en,  // consume tap 0 and shift the line
    output logic       o_src_v,     // a pixel is available at tap 0
    output logic [7:0] o_src_px,    // tap 0
    output logic [7:0] o_tap255,
    output logic [7:0] o_tap256
);

    logic       r_skid_v;
    logic [7:0] r_skid_px;
    logic [7:0] r_line [0:IMG_W-1];

    assign o_src_v  = r_skid_v | i_px_v;
    assign o_src_px = r_skid_v ? r_skid_px : i_px;
    assign o_tap255 = r_line[IMG_W-2];
    assign o_tap256 = r_line[IMG_W-1];

    // Skid register: park a returning pixel that cannot be consumed this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid_v  <= 1'b0;
            r_skid_px <= 8'd0;
        end else if (i_shift_en) begin
            r_skid_v  <= r_skid_v & i_px_v;
            r_skid_px <= i_px;
        end else if (i_px_v) begin
            r_skid_v  <= 1'b1;
            r_skid_px <= i_px;
        end else begin
            r_skid_v  <= r_skid_v;
            r_skid_px <= r_skid_px;
        end
    end

    // Delay line: shift tap 0 in whenever a pixel is consumed
    always_ff @(posedge clk) begin
        if (i_shift_en) begin
            r_line[0] <= o_src_px;
            for (int i = 1; i < IMG_W; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

endmodule

// File: rtl/ig_seq_ctrl.sv
// Frame sequencer for a 256x256 forward-difference gradient.
// Reads the image in raster order, delays it by one row, and writes
// {Gx, Gy} per pixel with valid/ready backpressure on the write side.
// FLUSH keeps the read counter running through 256 "virtual" reads that
// return zero, so row 255 drains with the same timing as every other row.
// Optional: define IG_PERF_CNT_EN to add the stall_cnt output.
module ig_seq_ctrl #(
    parameter int IMG_W = 256,
    parameter int AW    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       img_rd,
    output logic [AW-1:0]              img_addr,
    input  logic [7:0]                 img_di,
    output logic                       grad_wr,
    input  logic                       grad_ready,
    output logic [AW-1:0]              grad_addr,
    output logic [ig_pkg::GRAD_W-1:0]  grad_do,
    output logic                       busy,
`ifdef IG_PERF_CNT_EN
    output logic [15:0]                stall_cnt,
`endif
    output logic                       done
);
    import ig_pkg::*;

    localparam int            CW        = AW + 1;
    localparam logic [CW-1:0] FILL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] RD_LAST   = CW'(NUM_PIX - 1);
    localparam logic [CW-1:0] FLUSH_END = CW'(NUM_PIX + IMG_W);
    localparam logic [CW-1:0] ROW_OFS   = CW'(IMG_W);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_PIX - 1);

    ig_state_e         r_state;
    ig_state_e         w_state_n;
    logic              r_busy;
    logic              r_done;
    logic [CW-1:0]     r_rd_cnt;     // next read index, real then virtual
    logic [CW-1:0]     r_cons_cnt;   // index of the pixel at tap 0
    logic              r_px_v;       // a read was issued last cycle
    logic              r_px_virt;    // ...and it was a virtual (flush) read
    logic              r_grad_wr;
    logic [AW-1:0]     r_grad_addr;
    logic [GRAD_W-1:0] r_grad_do;

    logic              w_stall;
    logic              w_accept;
    logic              w_rd_en;
    logic              w_issue;
    logic              w_start_ok;
    logic              w_src_v;
    logic              w_shift;
    logic              w_emit;
    logic              w_last_col;
    logic              w_flush_px;
    logic [7:0]        w_px_in;
    logic [7:0]        w_src_px;
    logic [7:0]        w_tap255;
    logic [7:0]        w_tap256;
    logic [G_W-1:0]    w_gx;
    logic [G_W-1:0]    w_gy;
    logic [AW-1:0]     w_waddr;

    // A held write blocks everything upstream; reads stop in the same cycle
    // so the single skid entry is enough to absorb the in-flight pixel.
    assign w_stall    = r_grad_wr & ~grad_ready;
    assign w_accept   = r_grad_wr & grad_ready;
    assign w_issue    = w_rd_en & ~w_stall;
    assign w_start_ok = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));

    assign img_rd     = w_issue & ~r_rd_cnt[CW-1];
    assign img_addr   = r_rd_cnt[AW-1:0];
    assign grad_wr    = r_grad_wr;
    assign grad_addr  = r_grad_addr;
    assign grad_do    = r_grad_do;
    assign busy       = r_busy;
    assign done       = r_done;

    assign w_px_in    = r_px_virt ? 8'd0 : img_di;
    assign w_shift    = w_src_v & ~w_stall;
    assign w_emit     = w_shift & (r_cons_cnt >= ROW_OFS);
    assign w_last_col = (r_cons_cnt[7:0] == 8'hFF);
    assign w_flush_px = r_cons_cnt[CW-1];
    assign w_gx       = w_last_col ? {G_W{1'b0}} : pix_diff(w_tap255, w_tap256);
    assign w_gy       = w_flush_px ? {G_W{1'b0}} : pix_diff(w_src_px, w_tap256);
    assign w_waddr    = r_cons_cnt[AW-1:0] - ROW_OFS[AW-1:0];

    ig_line_buf u_line_buf (
        .clk        (clk),
        .reset      (reset),
        .i_px_v     (r_px_v),
        .i_px       (w_px_in),
        .i_shift_en (w_shift),
        .o_src_v    (w_src_v),
        .o_src_px   (w_src_px),
        .o_tap255   (w_tap255),
        .o_tap256   (w_tap256)
    );

    // Read enable: real reads in FILL/RUN, virtual zero reads in FLUSH
    always_comb begin
        w_rd_en = 1'b0;
        case (r_state)
            ST_FILL,
            ST_RUN:   w_rd_en = 1'b1;
            ST_FLUSH: w_rd_en = (r_rd_cnt != FLUSH_END);
            default:  w_rd_en = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_n = ST_FILL;
                else       w_state_n = ST_IDLE;
            end
            ST_FILL: begin
                if (w_issue && (r_rd_cnt == FILL_LAST)) w_state_n = ST_RUN;
                else                                    w_state_n = ST_FILL;
            end
            ST_RUN: begin
                if (w_issue && (r_rd_cnt == RD_LAST)) w_state_n = ST_FLUSH;
                else                                  w_state_n = ST_RUN;
            end
            ST_FLUSH: begin
                if (w_accept && (r_grad_addr == ADDR_LAST)) w_state_n = ST_DONE;
                else                                        w_state_n = ST_FLUSH;
            end
            ST_DONE: begin
                if (start) w_state_n = ST_FILL;
                else       w_state_n = ST_DONE;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // State register with registered busy/done decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_busy  <= (w_state_n == ST_FILL) | (w_state_n == ST_RUN) | (w_state_n == ST_FLUSH);
            r_done  <= (w_state_n == ST_DONE);
        end
    end

    // Read/consume counters and the one-cycle memory return tracker
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_cnt   <= {CW{1'b0}};
            r_cons_cnt <= {CW{1'b0}};
            r_px_v     <= 1'b0;
            r_px_virt  <= 1'b0;
        end else begin
            r_px_v    <= w_issue;
            r_px_virt <= r_rd_cnt[CW-1];
            if (w_start_ok) begin
                r_rd_cnt   <= {CW{1'b0}};
                r_cons_cnt <= {CW{1'b0}};
            end else begin
                if (w_issue) r_rd_cnt   <= r_rd_cnt + {{(CW-1){1'b0}}, 1'b1};
                else         r_rd_cnt   <= r_rd_cnt;
                if (w_shift) r_cons_cnt <= r_cons_cnt + {{(CW-1){1'b0}}, 1'b1};
                else         r_cons_cnt <= r_cons_cnt;
            end
        end
    end

    // Gradient output register: load on emit, hold while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grad_wr   <= 1'b0;
            r_grad_addr <= {AW{1'b0}};
            r_grad_do   <= {GRAD_W{1'b0}};
        end else if (w_stall) begin
            r_grad_wr   <= r_grad_wr;
            r_grad_addr <= r_grad_addr;
            r_grad_do   <= r_grad_do;
        end else if (w_emit) begin
            r_grad_wr   <= 1'b1;
            r_grad_addr <= w_waddr;
            r_grad_do   <= {w_gx, w_gy};
        end else begin
            r_grad_wr   <= 1'b0;
            r_grad_addr <= r_grad_addr;
            r_grad_do   <= r_grad_do;
        end
    end

`ifdef IG_PERF_CNT_EN
    logic [15:0] r_stall_cnt;

    assign stall_cnt = r_stall_cnt;

    // Saturating count of cycles with a write held by the memory
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_start_ok) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_ig_seq_ctrl.sv
// Directed bench for ig_seq_ctrl. Test image: row 0 = 255, rows 1-63 = 0,
// rows 64-127 = 100, rows 128-255 = x (ramp). This puts the step, flat and
// ramp cases into one frame.
module tb_ig_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        img_rd;
    logic [15:0] img_addr;
    logic [7:0]  img_di;
    logic        grad_wr;
    logic        grad_ready;
    logic [15:0] grad_addr;
    logic [19:0] grad_do;
    logic        busy;
    logic        done;
`ifdef IG_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_start = 0;

    // monitor state
    logic        mon_clr = 1'b1;
    int          acc_cnt, addr_err, data_err, hold_err, rd_err, stall_seen;
    int          t_first_wr, t_done;
    logic [15:0] first_wr_addr;
    logic        prev_stall;
    logic [15:0] prev_addr;
    logic [19:0] prev_do;
    logic [19:0] got_mem [0:65535];
    logic        found;

    ig_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .img_rd     (img_rd),
        .img_addr   (img_addr),
        .img_di     (img_di),
        .grad_wr    (grad_wr),
        .grad_ready (grad_ready),
        .grad_addr  (grad_addr),
        .grad_do    (grad_do),
        .busy       (busy),
`ifdef IG_PERF_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pix(input int x, input int y);
        if (y == 0)        return 8'd255;
        else if (y < 64)   return 8'd0;
        else if (y < 128)  return 8'd100;
        else               return 8'(x);
    endfunction

    function automatic logic [19:0] exp_grad(input logic [15:0] a);
        int x, y, gx, gy;
        x  = int'(a[7:0]);
        y  = int'(a[15:8]);
        gx = (x == 255) ? 0 : int'(pix(x + 1, y)) - int'(pix(x, y));
        gy = (y == 255) ? 0 : int'(pix(x, y + 1)) - int'(pix(x, y));
        return {gx[9:0], gy[9:0]};
    endfunction

    // Image memory: data one cycle after the read strobe
    always @(posedge clk) begin
        if (img_rd) img_di <= pix(int'(img_addr[7:0]), int'(img_addr[15:8]));
    end

    // Write-side monitor
    always @(negedge clk) begin
        if (mon_clr) begin
            acc_cnt = 0; addr_err = 0; data_err = 0; hold_err = 0; rd_err = 0;
            stall_seen = 0; t_first_wr = -1; t_done = -1; prev_stall = 1'b0;
            first_wr_addr = 16'hFFFF;
        end else begin
            if (prev_stall && !reset) begin
                if (grad_wr !== 1'b1 || grad_addr !== prev_addr || grad_do !== prev_do) hold_err++;
            end
            if (grad_wr === 1'b1 && t_first_wr < 0) begin
                t_first_wr    = cyc;
                first_wr_addr = grad_addr;
            end
            if (done === 1'b1 && t_done < 0) t_done = cyc;
            if (grad_wr === 1'b1 && grad_ready === 1'b1) begin
                if (grad_addr !== acc_cnt[15:0]) addr_err++;
                if (grad_do !== exp_grad(grad_addr)) data_err++;
                got_mem[grad_addr] = grad_do;
                acc_cnt++;
            end
            if (grad_wr === 1'b1 && grad_ready === 1'b0) begin
                stall_seen++;
                if (img_rd !== 1'b0) rd_err++;
            end
            prev_stall = (grad_wr === 1'b1) && (grad_ready === 1'b0);
            prev_addr  = grad_addr;
            prev_do    = grad_do;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        t_start = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        grad_ready = 1'b1;
        found      = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_img_rd",    {31'd0, img_rd},    32'd0);
        chk("rst_grad_wr",   {31'd0, grad_wr},   32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_img_addr",  {16'd0, img_addr},  32'd0);
        chk("rst_grad_addr", {16'd0, grad_addr}, 32'd0);
        chk("rst_grad_do",   {12'd0, grad_do},   32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // full frame, grad_ready = 1, with a stray start during RUN
        clear_mon();
        pulse_start();
        chk("a_busy",      {31'd0, busy},     32'd1);
        chk("a_first_rd",  {31'd0, img_rd},   32'd1);
        chk("a_first_adr", {16'd0, img_addr}, 32'd0);
        repeat (3000) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("a_busy_ign",  {31'd0, busy}, 32'd1);
        chk("a_done_ign",  {31'd0, done}, 32'd0);
        for (int i = 0; i < 70000 && done !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("a_done_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
        #1;
        chk("a_lat_first", t_first_wr - t_start, 32'd259);
        chk("a_lat_done",  t_done - t_start,     32'd65795);
        chk("a_first_ga",  {16'd0, first_wr_addr}, 32'd0);
        chk("a_accepts",   acc_cnt,  32'd65536);
        chk("a_addr_err",  addr_err, 32'd0);
        chk("a_data_err",  data_err, 32'd0);
        chk("a_step_x0",   {12'd0, got_mem[16'd0]},     32'h00301);
        chk("a_step_x255", {12'd0, got_mem[16'd255]},   32'h00301);
        chk("a_zero_r1",   {12'd0, got_mem[16'd300]},   32'h00000);
        chk("a_r63_up",    {12'd0, got_mem[16'd16135]}, 32'h00064);
        chk("a_r127_200",  {12'd0, got_mem[16'd32712]}, 32'h00064);
        chk("a_r127_50",   {12'd0, got_mem[16'd32562]}, 32'h003CE);
        chk("a_ramp_x5",   {12'd0, got_mem[16'd32773]}, 32'h00400);
        chk("a_ramp_x255", {12'd0, got_mem[16'd33023]}, 32'h00000);
        chk("a_last_row",  {12'd0, got_mem[16'd65290]}, 32'h00400);
        chk("a_end_busy",  {31'd0, busy},    32'd0);
        chk("a_end_wr",    {31'd0, grad_wr}, 32'd0);

        // random backpressure from DONE, then reset at grad_addr 1000
        clear_mon();
        pulse_start();
        chk("s_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8000 && !found; i++) begin
            @(posedge clk);
            #1 grad_ready = 1'($urandom_range(0, 1));
            if (grad_wr === 1'b1 && grad_addr === 16'd1000) found = 1'b1;
        end
        chk("s_reached_1000", {31'd0, found}, 32'd1);
`ifdef IG_PERF_CNT_EN
        chk("s_stall_cnt", {16'd0, stall_cnt}, stall_seen);
`endif
        chk("s_hold_err", hold_err, 32'd0);
        chk("s_rd_err",   rd_err,   32'd0);
        chk("s_addr_err", addr_err, 32'd0);
        chk("s_data_err", data_err, 32'd0);
        chk("s_accepts",  acc_cnt,  32'd1000);
        chk("s_stalled",  {31'd0, (stall_seen > 0)}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("r_img_rd",    {31'd0, img_rd},    32'd0);
        chk("r_grad_wr",   {31'd0, grad_wr},   32'd0);
        chk("r_busy",      {31'd0, busy},      32'd0);
        chk("r_grad_addr", {16'd0, grad_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        grad_ready = 1'b1;

        // restart after the abort
        clear_mon();
        pulse_start();
        chk("n_first_rd",  {31'd0, img_rd},   32'd1);
        chk("n_first_adr", {16'd0, img_addr}, 32'd0);
        for (int i = 0; i < 400 && t_first_wr < 0; i++) @(negedge clk);
        #1;
        chk("n_lat_first", t_first_wr - t_start, 32'd259);
        chk("n_first_ga",  {16'd0, first_wr_addr}, 32'd0);
        repeat (200) @(posedge clk);
        #1;
        chk("n_addr_err", addr_err, 32'd0);
        chk("n_data_err", data_err, 32'd0);
        chk("n_progress", {31'd0, (acc_cnt > 100)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ig_seq_ctrl.md
IG_SEQ_CTRL -- requirements
Module: ig_seq_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 256, meaning image width and height in pixels; only 256 is supported.
REQ-002 SHALL have parameter AW, default 16, meaning the address width of the image and gradient memories.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to process a frame; sampled only in IDLE or DONE.
REQ-006 SHALL have port img_rd, output, 1 bit: image memory read strobe.
REQ-007 SHALL have port img_addr, output, 16 bits: raster address y*256+x.
REQ-008 SHALL have port img_di, input, 8 bits: pixel, valid one cycle after img_rd.
REQ-009 SHALL have port grad_wr, output, 1 bit: gradient write valid.
REQ-010 SHALL have port grad_ready, input, 1 bit: the gradient memory accepts the write this cycle.
REQ-011 SHALL have port grad_addr, output, 16 bits: gradient write address.
REQ-012 SHALL have port grad_do, output, 20 bits: {Gx[9:0], Gy[9:0]}, each two's complement.
REQ-013 SHALL have port busy, output, 1 bit: high in every state other than IDLE and DONE.
REQ-014 SHALL have port done, output, 1 bit: high in DONE.

Function
REQ-015 SHALL implement the states IDLE, FILL, RUN, FLUSH and DONE.
  - IDLE -> FILL on start.
  - FILL -> RUN after 256 reads have been issued.
  - RUN -> FLUSH after the read of address 65535 is issued.
  - FLUSH -> DONE after the write to address 65535 is accepted.
  - DONE -> FILL on start.
REQ-016 SHALL issue reads in raster order from address 0 to 65535, at most one per cycle, with no gaps unless stalled.
REQ-017 SHALL shift each returned pixel into a 257-entry 8-bit delay line, where tap 256 = p(x,y) and tap 255 = p(x+1,y).
REQ-018 SHALL compute the gradient of pixel (x,y) on arrival of p(x,y+1):
  - Gx = p(x+1,y) - p(x,y), zero-extended to 10 bits before the subtract.
  - Gy = p(x,y+1) - p(x,y), zero-extended to 10 bits before the subtract.
REQ-019 SHALL force Gx to 0 when x = 255, with no wrap to the next row.
REQ-020 SHALL, in FLUSH, emit row 255 with Gy forced to 0, shifting zeros into the delay line, 256 writes.
REQ-021 SHALL register grad_wr, grad_addr and grad_do; a write appears 2 cycles after the img_rd that completes it.
REQ-022 SHALL treat a write as accepted only when grad_wr and grad_ready are both high.
REQ-023 SHALL hold grad_wr, grad_addr and grad_do stable while grad_wr is high and grad_ready is low.
REQ-024 SHALL deassert img_rd during a stall and capture the in-flight pixel in a 1-entry skid register, so that no pixel is lost or duplicated.
REQ-025 SHALL increment grad_addr by 1 per accepted write from 0 to 65535 and SHALL never wrap within a frame.
REQ-026 SHALL ignore start while busy is high.
REQ-027 SHALL NOT reorder grad_addr when start and the final accept occur in the same cycle; start is ignored in that cycle.

Reset
REQ-028 SHALL, on reset:
  - enter IDLE;
  - drive img_rd, grad_wr, busy and done to 0;
  - drive img_addr, grad_addr and grad_do to 0.
REQ-029 SHALL let reset asserted mid-frame abort the frame immediately; no partial-frame state survives, and the next start restarts at address 0.
REQ-030 SHALL NOT require the delay line to be cleared on reset; FILL overwrites it before first use.

Configuration
REQ-031 SHALL gate a stall counter with macro IG_PERF_CNT_EN.
  - Defined: output stall_cnt, 16 bits, counts cycles with grad_wr high and grad_ready low; saturates at 65535; cleared on reset and on start.
  - Undefined: the port and the counter are absent; all other behaviour is identical.

Structure
REQ-032 SHALL place the FSM state enum, IMG_W, the pixel count 65536, GRAD_W = 20 and the Gx/Gy width of 10 in package ig_pkg.
REQ-033 SHALL implement the delay line and skid register in sub-module ig_line_buf, with a shift-enable input and taps 255 and 256.

Verification
REQ-034 SHALL cover a flat image, all pixels 100, grad_ready = 1.
  - Response: 65536 writes, all grad_do = 0.
  - Response: first grad_wr 259 cycles after start, at grad_addr 0; done 65795 cycles after start.
REQ-035 SHALL cover a horizontal ramp p = x, grad_ready = 1.
  - Response: Gx = 1 for x < 255; Gx = 0 at x = 255; Gy = 0 everywhere.
REQ-036 SHALL cover an extreme step: row 0 = 255, all other rows = 0.
  - Response: grad at addresses 0-255 = {10'd0, -10'd255}, i.e. 20'h00301; all other addresses 0.
REQ-037 SHALL cover a stall: grad_ready pseudo-random, 50% low.
  - Response: grad_do and grad_addr held during each stall.
  - Response: exactly 65536 accepts with contiguous addresses; results match the REQ-034 to REQ-036 references.
REQ-038 SHALL cover a mid-frame reset: reset at grad_addr 1000, then start.
  - Response: img_rd and grad_wr drop at once; the next frame begins at img_addr 0 and grad_addr 0.
REQ-039 SHALL cover start while busy: start pulses during RUN.
  - Response: ignored, and with IG_PERF_CNT_EN defined, stall_cnt equals the count of stalled cycles.
